// File: rtl/mac_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl_if
// Bundles the start/result handshake and the datapath control outputs of the
// dot-product sequencer so they can be passed around as one port.
//
// Parameters (must match the sequencer instance that uses the bundle):
//   SEL_W    width of the weight/pixel mux selects
//   N_UNITS  width of the one-hot accumulator unit enable
//   PASS_W   width of the pass index
//
// Signals:
//   Input_Valid     start request from the producer
//   Input_Ready     sequencer can accept a start
//   Abort           synchronous cancel of the current job
//   Output_Ready    consumer takes the result
//   WeightX_Select  weight mux select
//   PixelX_Select   pixel mux select (identical to WeightX_Select)
//   ENX_Int         one-hot accumulator unit enable
//   ENX             one-cycle latch strobe at the end of each pass
//   Output_Valid    final result valid
//   Busy            sequencer is not idle
//   Pass_Idx        index of the pass in progress
//
// Modports:
//   master  the controlling side (issues starts, consumes results)
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface mac_seq_ctrl_if #(
    parameter int SEL_W   = 5,
    parameter int N_UNITS = 28,
    parameter int PASS_W  = 1
);
    logic               Input_Valid;
    logic               Input_Ready;
    logic               Abort;
    logic               Output_Ready;
    logic [SEL_W-1:0]   WeightX_Select;
    logic [SEL_W-1:0]   PixelX_Select;
    logic [N_UNITS-1:0] ENX_Int;
    logic               ENX;
    logic               Output_Valid;
    logic               Busy;
    logic [PASS_W-1:0]  Pass_Idx;

    modport master (
        output Input_Valid,
        output Abort,
        output Output_Ready,
        input  Input_Ready,
        input  WeightX_Select,
        input  PixelX_Select,
        input  ENX_Int,
        input  ENX,
        input  Output_Valid,
        input  Busy,
        input  Pass_Idx
    );

    modport slave (
        input  Input_Valid,
        input  Abort,
        input  Output_Ready,
        output Input_Ready,
        output WeightX_Select,
        output PixelX_Select,
        output ENX_Int,
        output ENX,
        output Output_Valid,
        output Busy,
        output Pass_Idx
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl
// Sequencer for the dot-product datapath. Each accepted start runs N_PASS
// passes. A pass sweeps the weight/pixel selects across N_TAPS taps, walks a
// one-hot enable across N_UNITS accumulator units (starting SHIFT_START cycles
// into the pass), lets TAIL settle cycles elapse and then pulses ENX for one
// cycle. After the last pass the result-valid flag is held until the consumer
// accepts it. Abort cancels a job at any point; reset does so asynchronously.
//
// Ports:
//   clk            single clock, rising edge
//   GlobalReset_n  asynchronous active-low reset
//   bus            handshake and datapath control bundle (slave side)
//
// Pass length in cycles:
//   RUN_LEN = max(N_TAPS, SHIFT_START + N_UNITS) + TAIL
// followed by one FIRE cycle, so each pass costs RUN_LEN + 1 cycles.
// -----------------------------------------------------------------------------
module mac_seq_ctrl #(
    parameter int N_TAPS      = 28,
    parameter int N_UNITS     = 28,
    parameter int SEL_W       = 5,
    parameter int SHIFT_START = 17,
    parameter int TAIL        = 7,
    parameter int N_PASS      = 1,
    parameter int PASS_W      = 1
) (
    input  logic          clk,
    input  logic          GlobalReset_n,
    mac_seq_ctrl_if.slave bus
);

    localparam int SPAN    = (N_TAPS > SHIFT_START + N_UNITS) ? N_TAPS
                                                                : SHIFT_START + N_UNITS;
    localparam int RUN_LEN = SPAN + TAIL;
    localparam int CNT_W   = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(RUN_LEN - 1);
    // Selects advance while cnt is below this value, then hold at N_TAPS-1.
    localparam logic [CNT_W-1:0]   SEL_STOP  = CNT_W'(N_TAPS - 1);
    localparam logic [PASS_W-1:0]  PASS_LAST = PASS_W'(N_PASS - 1);
    localparam logic [N_UNITS-1:0] UNIT0     = N_UNITS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIRE = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   sel_nxt;
    logic [N_UNITS-1:0] enx_int;
    logic [N_UNITS-1:0] enx_int_nxt;
    logic [PASS_W-1:0]  pass_idx;
    logic [PASS_W-1:0]  pass_idx_nxt;
    logic               shift_en;

    // With SHIFT_START = 0 the walk begins on the very first RUN cycle; the
    // comparison is only built when it can actually be false.
    generate
        if (SHIFT_START == 0) begin : g_shift_always
            assign shift_en = 1'b1;
        end else begin : g_shift_late
            assign shift_en = (cnt >= CNT_W'(SHIFT_START));
        end
    endgenerate

    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sel      <= '0;
            enx_int  <= '0;
            pass_idx <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sel      <= sel_nxt;
            enx_int  <= enx_int_nxt;
            pass_idx <= pass_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        sel_nxt      = sel;
        enx_int_nxt  = enx_int;
        pass_idx_nxt = pass_idx;

        if (bus.Abort) begin
            // Abort overrides everything, including a start offered in IDLE.
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            sel_nxt      = '0;
            enx_int_nxt  = '0;
            pass_idx_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    // Input_Ready is high exactly in IDLE, so a valid here is
                    // a completed start handshake.
                    if (bus.Input_Valid) begin
                        state_nxt    = RUN;
                        cnt_nxt      = '0;
                        sel_nxt      = '0;
                        enx_int_nxt  = UNIT0;
                        pass_idx_nxt = '0;
                    end
                end

                RUN: begin
                    if (cnt < SEL_STOP) begin
                        sel_nxt = sel + SEL_W'(1);
                    end
                    // Bits walking off the MSB are dropped, leaving zero
                    // for the rest of the pass.
                    if (shift_en) begin
                        enx_int_nxt = enx_int << 1;
                    end
                    if (cnt == CNT_LAST) begin
                        state_nxt = FIRE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end

                FIRE: begin
                    if (pass_idx != PASS_LAST) begin
                        // Next pass starts without any idle gap.
                        state_nxt    = RUN;
                        pass_idx_nxt = pass_idx + PASS_W'(1);
                        cnt_nxt      = '0;
                        sel_nxt      = '0;
                        enx_int_nxt  = UNIT0;
                    end else begin
                        state_nxt = DONE;
                    end
                end

                DONE: begin
                    if (bus.Output_Ready) begin
                        state_nxt    = IDLE;
                        sel_nxt      = '0;
                        enx_int_nxt  = '0;
                        pass_idx_nxt = '0;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Status and strobes are pure decodes of the state register, so none of
    // them has a combinational path from an input.
    assign bus.Input_Ready    = (state == IDLE);
    assign bus.Busy           = (state != IDLE);
    assign bus.ENX            = (state == FIRE);
    assign bus.Output_Valid   = (state == DONE);
    assign bus.WeightX_Select = sel;
    assign bus.PixelX_Select  = sel;
    assign bus.ENX_Int        = enx_int;
    assign bus.Pass_Idx       = pass_idx;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mac_seq_ctrl
// Bench for the dot-product sequencer. Three instances share clock and reset:
//   d=0  default sizing (RUN_LEN 52, one pass)
//   d=1  default sizing with three passes
//   d=2  small sizing: 4 taps, 3 units, walk from cycle 0, no tail (RUN_LEN 4)
// Directed scenarios check the documented cycle timing; a randomized scenario
// compares every output each cycle against a job-phase model that works from
// the number of cycles elapsed since the accepted start.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mac_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    mac_seq_ctrl_if #(.SEL_W(5), .N_UNITS(28), .PASS_W(1)) if0 ();
    mac_seq_ctrl_if #(.SEL_W(5), .N_UNITS(28), .PASS_W(2)) if1 ();
    mac_seq_ctrl_if #(.SEL_W(2), .N_UNITS(3),  .PASS_W(1)) if2 ();

    mac_seq_ctrl u_dut0 (
        .clk           (clk),
        .GlobalReset_n (rst_n),
        .bus           (if0.slave)
    );

    mac_seq_ctrl #(.N_PASS(3), .PASS_W(2)) u_dut1 (
        .clk           (clk),
        .GlobalReset_n (rst_n),
        .bus           (if1.slave)
    );

    mac_seq_ctrl #(
        .N_TAPS(4), .N_UNITS(3), .SEL_W(2), .SHIFT_START(0), .TAIL(0),
        .N_PASS(1), .PASS_W(1)
    ) u_dut2 (
        .clk           (clk),
        .GlobalReset_n (rst_n),
        .bus           (if2.slave)
    );

    logic iv   [3];
    logic ab   [3];
    logic ordy [3];

    assign if0.Input_Valid  = iv[0];
    assign if0.Abort        = ab[0];
    assign if0.Output_Ready = ordy[0];
    assign if1.Input_Valid  = iv[1];
    assign if1.Abort        = ab[1];
    assign if1.Output_Ready = ordy[1];
    assign if2.Input_Valid  = iv[2];
    assign if2.Abort        = ab[2];
    assign if2.Output_Ready = ordy[2];

    logic [7:0]  o_sel  [3];
    logic [7:0]  o_psel [3];
    logic [63:0] o_en   [3];
    logic        o_enx  [3];
    logic        o_ov   [3];
    logic        o_busy [3];
    logic        o_ir   [3];
    logic [7:0]  o_pass [3];

    assign o_sel[0]  = 8'(if0.WeightX_Select);
    assign o_psel[0] = 8'(if0.PixelX_Select);
    assign o_en[0]   = 64'(if0.ENX_Int);
    assign o_enx[0]  = if0.ENX;
    assign o_ov[0]   = if0.Output_Valid;
    assign o_busy[0] = if0.Busy;
    assign o_ir[0]   = if0.Input_Ready;
    assign o_pass[0] = 8'(if0.Pass_Idx);

    assign o_sel[1]  = 8'(if1.WeightX_Select);
    assign o_psel[1] = 8'(if1.PixelX_Select);
    assign o_en[1]   = 64'(if1.ENX_Int);
    assign o_enx[1]  = if1.ENX;
    assign o_ov[1]   = if1.Output_Valid;
    assign o_busy[1] = if1.Busy;
    assign o_ir[1]   = if1.Input_Ready;
    assign o_pass[1] = 8'(if1.Pass_Idx);

    assign o_sel[2]  = 8'(if2.WeightX_Select);
    assign o_psel[2] = 8'(if2.PixelX_Select);
    assign o_en[2]   = 64'(if2.ENX_Int);
    assign o_enx[2]  = if2.ENX;
    assign o_ov[2]   = if2.Output_Valid;
    assign o_busy[2] = if2.Busy;
    assign o_ir[2]   = if2.Input_Ready;
    assign o_pass[2] = 8'(if2.Pass_Idx);

    // {sel, psel, en, enx, ov, busy, ir, pass}
    localparam logic [91:0] RESET_VEC = {8'd0, 8'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};

    function automatic logic [91:0] pack(int d);
        return {o_sel[d], o_psel[d], o_en[d], o_enx[d], o_ov[d], o_busy[d], o_ir[d], o_pass[d]};
    endfunction

    // Sizing of each instance.
    function automatic int nt(int d); return (d == 2) ? 4 : 28; endfunction
    function automatic int nu(int d); return (d == 2) ? 3 : 28; endfunction
    function automatic int ss(int d); return (d == 2) ? 0 : 17; endfunction
    function automatic int tl(int d); return (d == 2) ? 0 : 7;  endfunction
    function automatic int np(int d); return (d == 1) ? 3 : 1;  endfunction

    function automatic int run_len(int d);
        int span;
        span = (nt(d) > ss(d) + nu(d)) ? nt(d) : ss(d) + nu(d);
        return span + tl(d);
    endfunction

    // t = 1 is the first cycle after the accept edge.
    function automatic bit is_done(int d, int t);
        return ((t - 1) / (run_len(d) + 1)) >= np(d);
    endfunction

    function automatic logic [91:0] exp_vec(int d, logic busy, int t);
        int          rl;
        int          p;
        int          r;
        logic [7:0]  s;
        logic [63:0] e;
        logic        f;
        logic        v;
        logic [7:0]  pi;
        if (!busy) return RESET_VEC;
        rl = run_len(d);
        p  = (t - 1) / (rl + 1);
        r  = (t - 1) % (rl + 1);
        f  = 1'b0;
        v  = 1'b0;
        if (p >= np(d)) begin
            s  = 8'(nt(d) - 1);
            e  = 64'd0;
            v  = 1'b1;
            pi = 8'(np(d) - 1);
        end else if (r == rl) begin
            s  = 8'(nt(d) - 1);
            e  = 64'd0;
            f  = 1'b1;
            pi = 8'(p);
        end else begin
            s  = 8'((r < nt(d) - 1) ? r : nt(d) - 1);
            if (r < ss(d))              e = 64'd1;
            else if (r < ss(d) + nu(d)) e = 64'd1 << (r - ss(d));
            else                        e = 64'd0;
            pi = 8'(p);
        end
        return {s, s, e, f, v, 1'b1, 1'b0, pi};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Force every instance back to IDLE with all inputs quiet.
    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            ab[d]   = 1'b1;
            ordy[d] = 1'b0;
        end
        step();
        for (int d = 0; d < 3; d++) ab[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            ab[d]   = 1'b0;
            ordy[d] = 1'b0;
        end
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (pack(d) !== RESET_VEC) begin
                n_err++;
                $display("FAIL reset_hold d=%0d got=%h exp=%h", d, pack(d), RESET_VEC);
            end
        end
        #3 rst_n = 1'b1;
        step();
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (pack(d) !== RESET_VEC) begin
                n_err++;
                $display("FAIL reset_release d=%0d got=%h exp=%h", d, pack(d), RESET_VEC);
            end
        end
    endtask

    task automatic test_default_timing();
        logic [7:0]  e_sel;
        logic [63:0] e_en;
        logic        e_enx;
        logic        e_ov;
        logic        e_ir;
        idle_all();
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        step();
        iv[0]   = 1'b0;
        for (int cyc = 1; cyc <= 56; cyc++) begin
            e_sel = (cyc <= 28) ? 8'(cyc - 1) : ((cyc <= 54) ? 8'd27 : 8'd0);
            e_en  = (cyc <= 18) ? 64'd1 : ((cyc <= 45) ? (64'd1 << (cyc - 18)) : 64'd0);
            e_enx = (cyc == 53);
            e_ov  = (cyc == 54);
            e_ir  = (cyc >= 55);
            n_vec++;
            if ({o_sel[0], o_psel[0], o_en[0], o_enx[0], o_ov[0], o_ir[0]} !==
                {e_sel, e_sel, e_en, e_enx, e_ov, e_ir}) begin
                n_err++;
                $display("FAIL default_timing cyc=%0d got sel=%0d psel=%0d en=%h enx=%b ov=%b ir=%b exp sel=%0d en=%h enx=%b ov=%b ir=%b",
                         cyc, o_sel[0], o_psel[0], o_en[0], o_enx[0], o_ov[0], o_ir[0],
                         e_sel, e_en, e_enx, e_ov, e_ir);
            end
            step();
        end
    endtask

    task automatic test_multipass();
        logic       e_enx;
        logic       e_ov;
        logic [7:0] e_pass;
        idle_all();
        ordy[1] = 1'b1;
        iv[1]   = 1'b1;
        step();
        iv[1]   = 1'b0;
        for (int cyc = 1; cyc <= 161; cyc++) begin
            e_enx  = (cyc == 53) || (cyc == 106) || (cyc == 159);
            e_ov   = (cyc == 160);
            e_pass = (cyc <= 53) ? 8'd0 : (cyc <= 106) ? 8'd1 : (cyc <= 160) ? 8'd2 : 8'd0;
            n_vec++;
            if ({o_enx[1], o_ov[1], o_pass[1]} !== {e_enx, e_ov, e_pass}) begin
                n_err++;
                $display("FAIL multipass cyc=%0d got enx=%b ov=%b pass=%0d exp enx=%b ov=%b pass=%0d",
                         cyc, o_enx[1], o_ov[1], o_pass[1], e_enx, e_ov, e_pass);
            end
            if (cyc == 1 || cyc == 54 || cyc == 107 || cyc == 53 || cyc == 106) begin
                n_vec++;
                if (o_sel[1] !== ((cyc == 53 || cyc == 106) ? 8'd27 : 8'd0)) begin
                    n_err++;
                    $display("FAIL multipass_sel cyc=%0d got=%0d exp=%0d", cyc, o_sel[1],
                             (cyc == 53 || cyc == 106) ? 27 : 0);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        idle_all();
        ordy[0] = 1'b0;
        iv[0]   = 1'b1;
        step();
        iv[0]   = 1'b0;
        repeat (53) step();
        // Cycle 54: result valid, consumer stalls while a new start is offered.
        for (int k = 0; k < 11; k++) begin
            iv[0] = (k < 10);
            n_vec++;
            if ({o_ov[0], o_busy[0], o_ir[0], o_enx[0]} !== 4'b1100) begin
                n_err++;
                $display("FAIL backpressure k=%0d got ov=%b busy=%b ir=%b enx=%b exp ov=1 busy=1 ir=0 enx=0",
                         k, o_ov[0], o_busy[0], o_ir[0], o_enx[0]);
            end
            if (k == 10) ordy[0] = 1'b1;
            step();
        end
        ordy[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (pack(0) !== RESET_VEC) begin
                n_err++;
                $display("FAIL backpressure_release k=%0d got=%h exp=%h", k, pack(0), RESET_VEC);
            end
            step();
        end
    endtask

    task automatic test_abort();
        idle_all();
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        step();
        iv[0]   = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            n_vec++;
            if ({o_enx[0], o_ov[0], o_busy[0]} !== 3'b001) begin
                n_err++;
                $display("FAIL abort_run cyc=%0d got enx=%b ov=%b busy=%b exp enx=0 ov=0 busy=1",
                         cyc, o_enx[0], o_ov[0], o_busy[0]);
            end
            if (cyc == 30) ab[0] = 1'b1;
            step();
        end
        ab[0] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            n_vec++;
            if (pack(0) !== RESET_VEC) begin
                n_err++;
                $display("FAIL abort_after k=%0d got=%h exp=%h", k, pack(0), RESET_VEC);
            end
            step();
        end
        ab[0] = 1'b1;
        iv[0] = 1'b1;
        step();
        ab[0] = 1'b0;
        iv[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (pack(0) !== RESET_VEC) begin
                n_err++;
                $display("FAIL abort_with_start k=%0d got=%h exp=%h", k, pack(0), RESET_VEC);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        idle_all();
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        step();
        iv[0]   = 1'b0;
        repeat (39) step();
        n_vec++;
        if ({o_busy[0], o_en[0]} !== {1'b1, 64'd1 << 22}) begin
            n_err++;
            $display("FAIL async_reset_pre got busy=%b en=%h exp busy=1 en=%h",
                     o_busy[0], o_en[0], 64'd1 << 22);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (pack(0) !== RESET_VEC) begin
            n_err++;
            $display("FAIL async_reset_clear got=%h exp=%h", pack(0), RESET_VEC);
        end
        #3 rst_n = 1'b1;
        step();
        n_vec++;
        if (pack(0) !== RESET_VEC) begin
            n_err++;
            $display("FAIL async_reset_release got=%h exp=%h", pack(0), RESET_VEC);
        end
        test_default_timing();
    endtask

    task automatic test_small_config();
        logic [7:0]  e_sel;
        logic [63:0] e_en;
        logic        e_enx;
        logic        e_ov;
        logic        e_ir;
        idle_all();
        ordy[2] = 1'b1;
        iv[2]   = 1'b1;
        step();
        iv[2]   = 1'b0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            e_sel = (cyc <= 4) ? 8'(cyc - 1) : ((cyc <= 6) ? 8'd3 : 8'd0);
            e_en  = (cyc <= 3) ? (64'd1 << (cyc - 1)) : 64'd0;
            e_enx = (cyc == 5);
            e_ov  = (cyc == 6);
            e_ir  = (cyc == 7);
            n_vec++;
            if ({o_sel[2], o_psel[2], o_en[2], o_enx[2], o_ov[2], o_ir[2]} !==
                {e_sel, e_sel, e_en, e_enx, e_ov, e_ir}) begin
                n_err++;
                $display("FAIL small_config cyc=%0d got sel=%0d psel=%0d en=%h enx=%b ov=%b ir=%b exp sel=%0d en=%h enx=%b ov=%b ir=%b",
                         cyc, o_sel[2], o_psel[2], o_en[2], o_enx[2], o_ov[2], o_ir[2],
                         e_sel, e_en, e_enx, e_ov, e_ir);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic e_enx;
        logic e_ov;
        logic e_ir;
        idle_all();
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        step();
        for (int cyc = 1; cyc <= 112; cyc++) begin
            e_enx = (cyc == 53) || (cyc == 108);
            e_ov  = (cyc == 54) || (cyc == 109);
            e_ir  = (cyc == 55) || (cyc == 110);
            n_vec++;
            if ({o_enx[0], o_ov[0], o_ir[0], o_busy[0]} !== {e_enx, e_ov, e_ir, ~e_ir}) begin
                n_err++;
                $display("FAIL back_to_back cyc=%0d got enx=%b ov=%b ir=%b busy=%b exp enx=%b ov=%b ir=%b busy=%b",
                         cyc, o_enx[0], o_ov[0], o_ir[0], o_busy[0], e_enx, e_ov, e_ir, ~e_ir);
            end
            step();
        end
        iv[0] = 1'b0;
    endtask

    task automatic test_random_traffic(int d, int ncyc);
        logic busy;
        int   t;
        idle_all();
        busy = 1'b0;
        t    = 0;
        for (int k = 0; k < ncyc; k++) begin
            iv[d]   = ($urandom_range(3) == 0);
            ab[d]   = ($urandom_range(149) == 0);
            ordy[d] = ($urandom_range(2) == 0);
            if (ab[d]) begin
                busy = 1'b0;
            end else if (!busy) begin
                if (iv[d]) begin
                    busy = 1'b1;
                    t    = 1;
                end
            end else if (is_done(d, t)) begin
                if (ordy[d]) busy = 1'b0;
            end else begin
                t++;
            end
            step();
            n_vec++;
            if (pack(d) !== exp_vec(d, busy, t)) begin
                n_err++;
                $display("FAIL random d=%0d k=%0d got=%h exp=%h", d, k, pack(d), exp_vec(d, busy, t));
            end
        end
        iv[d]   = 1'b0;
        ab[d]   = 1'b0;
        ordy[d] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_timing();
        test_multipass();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_small_config();
        test_back_to_back();
        test_random_traffic(0, 2500);
        test_random_traffic(1, 3000);
        test_random_traffic(2, 800);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Parametrised sequencer for the dot-product datapath. Once per accepted start it sweeps the weight and pixel mux selects across `N_TAPS` taps and walks a one-hot enable across `N_UNITS` accumulator units. It then fires a one-cycle latch strobe and holds a result-valid flag until the consumer takes it. It replaces the fixed 28-tap controller, adding a ready/valid handshake on both sides, multi-pass operation, a synchronous abort, and sizing set entirely by parameters.

## Interface
- `N_TAPS`, 28: number of weight/pixel taps per pass (≥2)
- `N_UNITS`, 28: width of the one-hot unit-enable vector (≥1)
- `SEL_W`, 5: select width; must be ≥ clog2(`N_TAPS`)
- `SHIFT_START`, 17: RUN cycle index at which the enable walk begins (≥0)
- `TAIL`, 7: settle cycles after the last tap/enable activity (≥0)
- `N_PASS`, 1: passes per accepted start (≥1)
- `PASS_W`, 1: width of `Pass_Idx`; must be ≥ max(1, clog2(`N_PASS`))
- `clk` in 1: single clock, rising edge
- `GlobalReset_n` in 1: reset, asynchronous assert, active-low
- `Input_Valid` in 1: start request, sampled on `clk`
- `Input_Ready` out 1: block can accept a start (high only in IDLE)
- `Abort` in 1: synchronous cancel, active-high
- `Output_Ready` in 1: consumer accepts the result
- `WeightX_Select` out `SEL_W`: weight mux select
- `PixelX_Select` out `SEL_W`: pixel mux select; always equal to `WeightX_Select`
- `ENX_Int` out `N_UNITS`: one-hot unit enable
- `ENX` out 1: one-cycle accumulator latch strobe at the end of each pass
- `Output_Valid` out 1: final result valid
- `Busy` out 1: high in any state other than IDLE
- `Pass_Idx` out `PASS_W`: index of the current pass

## Operation
- States: IDLE, RUN, FIRE, DONE.
- The block has an internal cycle counter `cnt`, sized to hold RUN_LEN-1.
- RUN_LEN = max(`N_TAPS`, `SHIFT_START`+`N_UNITS`) + `TAIL`.
- Reset values: state IDLE, selects 0, `ENX_Int` 0, `ENX` 0, `Output_Valid` 0, `Pass_Idx` 0, `Busy` 0, `Input_Ready` 1.
- IDLE:
  - When `Input_Valid` and `Input_Ready` are both high at a clock edge, the block moves to RUN.
  - On that edge: `cnt`=0, selects=0, `ENX_Int`=1 (bit 0), `Pass_Idx`=0.
- RUN, during the cycle with `cnt`=c:
  - Selects = min(c, `N_TAPS`-1). They increment on the edge ending cycle c while c ≤ `N_TAPS`-2, then hold.
  - `ENX_Int`: bit 0 while c < `SHIFT_START`.
  - `ENX_Int`: 1<<(c-`SHIFT_START`) while `SHIFT_START` ≤ c < `SHIFT_START`+`N_UNITS`.
  - `ENX_Int`: all zero afterwards. It shifts left on every edge ending a cycle with c ≥ `SHIFT_START`; the bit shifted out of the MSB is discarded.
  - The edge ending c = RUN_LEN-1 moves the block to FIRE.
- FIRE (one cycle): `ENX`=1. On the next edge:
  - If `Pass_Idx` < `N_PASS`-1: go to RUN with `Pass_Idx`+1, `cnt`=0, selects=0, `ENX_Int`=1.
  - Otherwise: go to DONE.
- DONE:
  - `Output_Valid`=1, held until the first edge where `Output_Ready`=1.
  - That edge returns the block to IDLE, clears `Output_Valid`, selects, `ENX_Int` and `Pass_Idx`.
- `Input_Valid` is ignored outside IDLE. No start is queued while busy.
- `Abort` at an edge in any state sends the block to IDLE with all outputs at reset values. No `ENX` or `Output_Valid` is produced for the aborted job.
- `Abort` and `Input_Valid` at the same edge in IDLE: `Abort` wins and the start is not accepted.
- Reset asserted mid-job: every output goes to its reset value immediately, without waiting for a clock edge. The job is lost.
- `ENX`, `Output_Valid`, `Busy` and `Input_Ready` are decoded from registered state only, with no combinational path from any input.

## Timing
- Accept edge = edge 0. RUN occupies cycles 1..RUN_LEN.
- `ENX` is high in cycle RUN_LEN+1 of the final pass.
- `Output_Valid` rises in cycle (RUN_LEN+1)·`N_PASS`+1.
- Defaults: RUN_LEN=52. `ENX` in cycle 53, `Output_Valid` from cycle 54.
- Each extra pass adds RUN_LEN+1 cycles. There are no idle cycles between passes.
- After the DONE handshake edge the block is in IDLE. The earliest next accept is the following edge, so a new job starts 1 cycle after `Output_Ready` is taken.

## Test plan
- Defaults, `Input_Valid` pulse, `Output_Ready`=1:
  - selects read 0,1,…,27 during cycles 1..28 and hold at 27 until FIRE.
  - `ENX_Int` is 1 for cycles 1..18, bit k in cycle 18+k, and 0 from cycle 46.
  - `ENX` is high only in cycle 53; `Output_Valid` is high only in cycle 54.
  - `Input_Ready` rises in cycle 55.
- `N_PASS`=3, defaults otherwise:
  - `ENX` is high in cycles 53, 106 and 159.
  - `Pass_Idx` steps 0→1→2, and selects restart at 0 in cycles 54 and 107.
  - `Output_Valid` rises in cycle 160.
- Backpressure: hold `Output_Ready`=0 for 10 cycles after `Output_Valid` rises.
  - `Output_Valid` stays high and state stays DONE.
  - A start offered during that time is ignored.
  - Raising `Output_Ready` gives IDLE on the next edge.
- `Abort` in cycle 30 (defaults): all outputs return to reset values on the next edge, and `ENX` and `Output_Valid` never assert. `Abort` together with `Input_Valid` in IDLE: the block stays in IDLE.
- `GlobalReset_n` low between clock edges in cycle 40: outputs clear immediately. After release, a fresh start reproduces the scenario-1 timing exactly.
- `N_TAPS`=4, `N_UNITS`=3, `SHIFT_START`=0, `TAIL`=0, `SEL_W`=2, giving RUN_LEN=4:
  - selects read 0,1,2,3 in cycles 1..4.
  - `ENX_Int` reads 001, 010, 100, 000 in cycles 1..4.
  - `ENX` is high in cycle 5; `Output_Valid` rises in cycle 6.
